// File: rtl/match_scanner_if.sv
// match_scanner_if: table write, scan handshake and result bus for match_scanner
interface match_scanner_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
);
  logic             wr_en;
  logic [IDXW-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [WIDTH-1:0] key;
  logic             busy;
  logic             done;
  logic             found;
  logic [IDXW-1:0]  match_idx;
  logic [IDXW:0]    match_cnt;
  modport master(output wr_en, wr_addr, wr_data, start, key,
                 input busy, done, found, match_idx, match_cnt);
  modport slave(input wr_en, wr_addr, wr_data, start, key,
                output busy, done, found, match_idx, match_cnt);
endinterface

// File: rtl/match_scanner.sv
// match_scanner: one-entry-per-clock key search; MATCH_SCANNER_COUNT_EN adds a full-table match counter
module match_scanner #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  match_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] key_q, diff;
  logic [IDXW-1:0]  ptr_q, idx_q;
  logic             found_q, hit, last, stop;
  always_comb begin
    diff = mem_q[ptr_q] - key_q;
    hit  = (state_q == SCAN) && (diff == '0);
    last = ptr_q == IDXW'(DEPTH - 1);
`ifdef MATCH_SCANNER_COUNT_EN
    stop = last;
`else
    stop = last || hit;
`endif
    state_d = state_q == IDLE ? (bus.start ? SCAN : IDLE)
            : state_q == SCAN ? (stop ? DONE : SCAN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
      if (state_q == IDLE && bus.start) begin
        key_q   <= bus.key;
        ptr_q   <= '0;
        idx_q   <= '0;
        found_q <= 1'b0;
      end else if (state_q == SCAN) begin
        if (!last) ptr_q <= ptr_q + 1'b1;
        // only the first hit sets the index, so it stays the lowest one
        if (hit && !found_q) begin
          found_q <= 1'b1;
          idx_q   <= ptr_q;
        end
      end
    end
  end
`ifdef MATCH_SCANNER_COUNT_EN
  logic [IDXW:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (state_q == IDLE && bus.start) cnt_q <= '0;
    else if (hit) cnt_q <= cnt_q + 1'b1;
  end
  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = '0;
`endif
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  assign bus.found     = found_q;
  assign bus.match_idx = idx_q;
endmodule

// File: tb/tb_match_scanner.sv
// tb_match_scanner: directed vector table plus hand sequences for match_scanner
module tb_match_scanner;
`ifdef MATCH_SCANNER_COUNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  always #5 clk = ~clk;
  match_scanner_if #(.WIDTH(32), .DEPTH(8)) bus();
  match_scanner #(.WIDTH(32), .DEPTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] key;
    logic        f;
    logic [2:0]  idx;
    logic [3:0]  cnt;
    int          lat;
  } vec_t;
  vec_t v[10];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic do_scan(input string nm, input logic [31:0] k, input bit disturb,
                         input logic f, input logic [2:0] idx, input logic [3:0] cnt, input int lat);
    int n;
    bus.start = 1'b1; bus.key = k;
    tick();
    bus.start = 1'b0; bus.wr_en = 1'b0; bus.key = ~k;
    chk({nm, " busy_e0"}, bus.busy, 1'b1);
    n = 0;
    if (disturb) begin
      bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = k;
      bus.start = 1'b1; bus.key = 32'h11111111;
      tick();
      bus.wr_en = 1'b0; bus.start = 1'b0;
      n = 1;
    end
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, n, CNT ? 8 : lat);
    chk({nm, " found"}, bus.found, f);
    chk({nm, " match_idx"}, bus.match_idx, idx);
    chk({nm, " match_cnt"}, bus.match_cnt, CNT ? cnt : 4'd0);
    tick();
    chk({nm, " done_pulse"}, {bus.done, bus.busy}, 2'b00);
    chk({nm, " hold_idx"}, bus.match_idx, idx);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit bad;
    v[0] = '{32'h33333333, 1'b1, 3'd3, 4'd1, 4};
    v[1] = '{32'hDEADBEEF, 1'b0, 3'd0, 4'd0, 8};
    v[2] = '{32'h00000000, 1'b1, 3'd0, 4'd1, 1};
    v[3] = '{32'h77777777, 1'b1, 3'd7, 4'd1, 8};
    v[4] = '{32'h80000000, 1'b0, 3'd0, 4'd0, 8};
    v[5] = '{32'hFFFFFFFF, 1'b1, 3'd2, 4'd3, 3};
    v[6] = '{32'h7FFFFFFF, 1'b0, 3'd0, 4'd0, 8};
    v[7] = '{32'h55555555, 1'b0, 3'd0, 4'd0, 8};
    v[8] = '{32'h66666666, 1'b1, 3'd6, 4'd1, 7};
    v[9] = '{32'h22222222, 1'b0, 3'd0, 4'd0, 8};
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0; bus.key = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset outputs", {bus.busy, bus.done, bus.found, bus.match_idx, bus.match_cnt}, '0);
    for (int k = 0; k < 8; k++) wr(3'(k), 32'h11111111 * k);
    for (int i = 0; i < 5; i++)
      do_scan($sformatf("vec%0d", i), v[i].key, 1'b0, v[i].f, v[i].idx, v[i].cnt, v[i].lat);
    wr(3'd2, 32'hFFFFFFFF); wr(3'd5, 32'hFFFFFFFF); wr(3'd7, 32'hFFFFFFFF);
    for (int i = 5; i < 10; i++)
      do_scan($sformatf("vec%0d", i), v[i].key, 1'b0, v[i].f, v[i].idx, v[i].cnt, v[i].lat);
    do_scan("ignored_inputs", 32'h44444444, 1'b1, 1'b1, 3'd4, 4'd1, 5);
    do_scan("readback6", 32'h66666666, 1'b0, 1'b1, 3'd6, 4'd1, 7);
    bus.start = 1'b1; bus.key = 32'h66666666;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_scan_reset outputs", {bus.busy, bus.done, bus.found, bus.match_idx, bus.match_cnt}, '0);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done || bus.busy) bad = 1'b1;
    end
    chk("no_done_after_reset", bad, 1'b0);
    do_scan("cleared_key0", 32'h00000000, 1'b0, 1'b1, 3'd0, 4'd8, 1);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 32'hA5A5A5A5;
    do_scan("write_with_start", 32'hA5A5A5A5, 1'b0, 1'b1, 3'd1, 4'd1, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
